// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Glyph table, scan FSM encoding and blank constant for seg7 driver
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] c_SEG_BLANK = 7'h00;

  // Active-high glyphs, bit0=a .. bit6=g; entry n is the glyph for nibble n.
  localparam logic [15:0][6:0] c_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_deco.sv
`default_nettype none
// ============================================================================
// Module  : deco_hex_7seg
// Brief   : Combinational hex nibble to active-high 7-segment glyph decoder
// Revision: 1.0 - initial release
// ============================================================================
module deco_hex_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Seg
);

  assign o_Seg = c_GLYPHS[i_Nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : Multiplexed 7-segment scan driver with ghosting guard and
//           frame-synchronous (tear-free) value update.
//           Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int COMMON_ANODE = 0
)(
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_DpMask,
  output logic [6:0]              o_Segmentos,
  output logic                    o_Dp,
  output logic [NUM_DIGITS-1:0]   o_Digito,
  output logic                    o_Frame
);

  localparam int c_CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam int c_IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK_CYCLES - 1);
  localparam logic [c_CW-1:0] c_SHOW_LAST  = c_CW'(SCAN_DIV - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);
  localparam logic            c_INV        = (COMMON_ANODE != 0);

  state_t                  r_state;
  logic [c_CW-1:0]         r_cnt;
  logic [c_IW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_active_val;
  logic [NUM_DIGITS-1:0]   r_active_dp;

  logic                    w_blank_done;
  logic                    w_show_done;
  logic                    w_show_nxt;
  logic                    w_wrap;
  logic [3:0]              w_nibble;
  logic                    w_dp_sel;
  logic [NUM_DIGITS-1:0]   w_digit_sel;
  logic [6:0]              w_seg_raw;
  logic [6:0]              w_seg_lit;
  logic                    w_lz_blank;

  assign w_blank_done = (r_state == ST_BLANK) && (r_cnt == c_BLANK_LAST);
  assign w_show_done  = (r_state == ST_SHOW)  && (r_cnt == c_SHOW_LAST);
  assign w_show_nxt   = w_blank_done || ((r_state == ST_SHOW) && !w_show_done);
  assign w_wrap       = w_show_done && (r_idx == c_IDX_LAST);

  always_comb begin
    w_nibble    = 4'h0;
    w_dp_sel    = 1'b0;
    w_digit_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == c_IW'(k)) begin
        w_nibble       = r_active_val[4*k +: 4];
        w_dp_sel       = r_active_dp[k];
        w_digit_sel[k] = 1'b1;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [c_IW-1:0] w_msnz;

  always_comb begin
    w_msnz = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_active_val[4*k +: 4] != 4'h0) begin
        w_msnz = c_IW'(k);
      end
    end
  end

  assign w_lz_blank = (r_idx > w_msnz);
`else
  assign w_lz_blank = 1'b0;
`endif

  deco_hex_7seg u_deco (
    .i_Nibble (w_nibble),
    .o_Seg    (w_seg_raw)
  );

  assign w_seg_lit = w_lz_blank ? c_SEG_BLANK : w_seg_raw;

  // Display outputs are registered from the next state so they track the FSM with no lag.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
      o_Frame      <= 1'b0;
      o_Segmentos  <= {7{c_INV}};
      o_Dp         <= c_INV;
      o_Digito     <= {NUM_DIGITS{c_INV}};
    end else begin
      if (i_Load) begin
        r_shadow_val <= i_Value;
        r_shadow_dp  <= i_DpMask;
      end

      case (r_state)
        ST_BLANK: begin
          if (w_blank_done) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        ST_SHOW: begin
          if (w_show_done) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            if (w_wrap) begin
              r_idx        <= '0;
              r_active_val <= r_shadow_val;
              r_active_dp  <= r_shadow_dp;
            end else begin
              r_idx <= r_idx + c_IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
        end
      endcase

      o_Frame <= w_wrap;

      if (w_show_nxt) begin
        o_Segmentos <= w_seg_lit ^ {7{c_INV}};
        o_Dp        <= w_dp_sel ^ c_INV;
        o_Digito    <= w_digit_sel ^ {NUM_DIGITS{c_INV}};
      end else begin
        o_Segmentos <= {7{c_INV}};
        o_Dp        <= c_INV;
        o_Digito    <= {NUM_DIGITS{c_INV}};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Randomized self-checking bench for seg7_scan_driver (CC and CA)
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + S;
  localparam int FRAME = N * SLOT;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_Load;
  logic [15:0] i_Value;
  logic [3:0]  i_DpMask;

  logic [6:0]  seg_cc, seg_ca;
  logic        dp_cc, dp_ca;
  logic [3:0]  dig_cc, dig_ca;
  logic        fr_cc, fr_ca;

  int checks = 0;
  int errors = 0;

  // Reference state: edges since reset release, plus shadow/active contents.
  int          m_e = 0;
  logic [15:0] m_sh_v = '0, m_ac_v = '0;
  logic [3:0]  m_sh_dp = '0, m_ac_dp = '0;

  logic [6:0] glyph_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B), .COMMON_ANODE(0)
  ) u_dut_cc (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Load(i_Load), .i_Value(i_Value),
    .i_DpMask(i_DpMask), .o_Segmentos(seg_cc), .o_Dp(dp_cc),
    .o_Digito(dig_cc), .o_Frame(fr_cc)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B), .COMMON_ANODE(1)
  ) u_dut_ca (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Load(i_Load), .i_Value(i_Value),
    .i_DpMask(i_DpMask), .o_Segmentos(seg_ca), .o_Dp(dp_ca),
    .o_Digito(dig_ca), .o_Frame(fr_ca)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h edge=%0d t=%0t", tag, act, exp, m_e, $time);
    end
  endtask

  task automatic check_all();
    int pos, slot, phase, msnz;
    bit lit;
    logic [6:0] seg;
    logic [3:0] dig;
    logic dp, fr;
    pos   = m_e % FRAME;
    slot  = pos / SLOT;
    phase = pos % SLOT;
    lit   = rst_n && (phase >= B);
    seg   = glyph_tab[m_ac_v[slot*4 +: 4]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    msnz = 0;
    for (int k = 0; k < N; k++) if (m_ac_v[k*4 +: 4] != 4'h0) msnz = k;
    if (slot > msnz) seg = 7'h00;
`else
    msnz = 0;
`endif
    dig = 4'(1 << slot);
    dp  = m_ac_dp[slot];
    if (!lit) begin
      seg = 7'h00; dig = 4'h0; dp = 1'b0;
    end
    fr = rst_n && (m_e > 0) && (pos == 0);
    chk("cc_seg", 32'(seg_cc), 32'(seg));
    chk("cc_dp",  32'(dp_cc),  32'(dp));
    chk("cc_dig", 32'(dig_cc), 32'(dig));
    chk("cc_frame", 32'(fr_cc), 32'(fr));
    chk("ca_seg", 32'(seg_ca), 32'(7'(~seg)));
    chk("ca_dp",  32'(dp_ca),  32'(!dp));
    chk("ca_dig", 32'(dig_ca), 32'(4'(~dig)));
    chk("ca_frame", 32'(fr_ca), 32'(fr));
  endtask

  task automatic tick(input bit ld, input logic [15:0] v, input logic [3:0] dpm);
    i_Load = ld; i_Value = v; i_DpMask = dpm;
    @(posedge clk);
    if (rst_n) begin
      m_e++;
      if (m_e % FRAME == 0) begin
        m_ac_v  = m_sh_v;
        m_ac_dp = m_sh_dp;
      end
      if (ld) begin
        m_sh_v  = v;
        m_sh_dp = dpm;
      end
    end
    #1;
    i_Load = 1'b0;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0);
  endtask

  task automatic run_to(input int slot, input int phase);
    bit found = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      if (((m_e % FRAME) / SLOT == slot) && ((m_e % FRAME) % SLOT == phase)) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 16'h0, 4'h0);
    end
    if (!found) begin
      errors++;
      $display("FAIL run_to timeout slot=%0d phase=%0d", slot, phase);
    end
  endtask

  // Position so that the next edge is the wrap edge.
  task automatic run_to_prewrap();
    run_to(N-1, SLOT-1);
  endtask

  initial begin
    i_Load = 1'b0; i_Value = '0; i_DpMask = '0;
    rst_n = 1'b0;
    #1;
    check_all();
    run(3);
    rst_n = 1'b1;

    tick(1'b1, 16'h1234, 4'h0);
    run(2*FRAME);

    for (int v = 0; v < 16; v++) begin
      tick(1'b1, 16'(v), 4'h0);
      run(2*FRAME);
    end

    run_to(1, 3);
    tick(1'b1, 16'hAAAA, 4'h3);
    run(3);
    tick(1'b1, 16'h5555, 4'h0);
    run(2*FRAME);

    run_to_prewrap();
    tick(1'b1, 16'h9876, 4'h8);
    run(2*FRAME);

    tick(1'b1, 16'h0C0D, 4'b0100);
    run(2*FRAME);

    tick(1'b1, 16'h0007, 4'h0);
    run(2*FRAME);
    tick(1'b1, 16'h0000, 4'h1);
    run(2*FRAME);
    tick(1'b1, 16'h00E0, 4'h0);
    run(2*FRAME);

    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(5) == 0), 16'($urandom), 4'($urandom));
    end

    tick(1'b1, 16'hFEDC, 4'hF);
    run(FRAME);
    run_to(2, B + 1);
    rst_n = 1'b0;
    m_e = 0; m_sh_v = '0; m_ac_v = '0; m_sh_dp = '0; m_ac_dp = '0;
    #1;
    check_all();
    run(3);
    rst_n = 1'b1;
    run(FRAME + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL provide parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL provide parameter SCAN_DIV, default 50000, clocks each digit is lit per scan slot (legal >=1).
REQ-003 The block SHALL provide parameter BLANK_CYCLES, default 16, clocks of all-off ghosting guard before each slot (legal >=1).
REQ-004 The block SHALL provide parameter COMMON_ANODE, default 0, where 1 inverts all segment, dp and digit outputs.
REQ-005 i_Clk  input  1  single clock, all logic on rising edge.
REQ-006 i_Rst_n  input  1  asynchronous active-low reset.
REQ-007 i_Load  input  1  capture strobe for i_Value/i_DpMask.
REQ-008 i_Value  input  4*NUM_DIGITS  hex nibbles, digit k = bits [4k+3:4k], digit 0 least significant.
REQ-009 i_DpMask  input  NUM_DIGITS  decimal point request per digit.
REQ-010 o_Segmentos  output  7  segments, bit0=a .. bit6=g, 1=lit when COMMON_ANODE=0.
REQ-011 o_Dp  output  1  decimal point of active digit.
REQ-012 o_Digito  output  NUM_DIGITS  one-hot digit enable, 1=on when COMMON_ANODE=0.
REQ-013 o_Frame  output  1  one-cycle pulse at each scan wrap.

Function
REQ-014 Decode SHALL map 0-9 and A,b,C,d,E,F to standard glyphs (e.g. 0=7'h3F, 8=7'h7F, F=7'h71, b=7'h7C).
REQ-015 FSM SHALL have states BLANK and SHOW; BLANK lasts BLANK_CYCLES clocks, SHOW lasts SCAN_DIV clocks, then BLANK.
REQ-016 In BLANK all o_Digito, o_Segmentos, o_Dp SHALL be inactive.
REQ-017 In SHOW exactly one o_Digito bit (current index) SHALL be active, with segments/dp of that digit from the active register.
REQ-018 Digit index SHALL increment at SHOW->BLANK, wrapping NUM_DIGITS-1 -> 0; frame length = NUM_DIGITS*(BLANK_CYCLES+SCAN_DIV) clocks.
REQ-019 o_Frame SHALL pulse high for the single clock in which the index wraps to 0.
REQ-020 i_Load=1 on an edge SHALL copy i_Value/i_DpMask into a shadow register; multiple loads within one frame: last wins.
REQ-021 Shadow SHALL transfer to the active register on the wrap clock only, so a frame never mixes old and new values (no tearing).
REQ-022 i_Load asserted on the wrap clock SHALL land in shadow and be displayed from the following frame, not the current one.
REQ-023 All outputs SHALL be registered; output change lags the FSM state change by at most one clock, uniformly for all outputs.
REQ-024 Counters SHALL be $clog2-sized, never overflow, and NUM_DIGITS=1 SHALL keep the index constant 0 with o_Frame each slot.

Reset
REQ-025 While i_Rst_n=0: state BLANK, counters 0, index 0, shadow and active registers 0, o_Frame 0, all display outputs inactive (polarity per COMMON_ANODE).
REQ-026 Reset asserted mid-slot SHALL force outputs inactive immediately (asynchronously); after release the first lit slot is digit 0 after BLANK_CYCLES clocks.

Configuration
REQ-027 Macro SEG7_LEADING_ZERO_BLANK_EN, when defined, SHALL blank segments of every digit above the most significant nonzero nibble of the active register; digit 0 always shown; dp still per mask; digit timing unchanged.
REQ-028 Without SEG7_LEADING_ZERO_BLANK_EN every digit SHALL show its decoded nibble including leading zeros.

Structure
REQ-029 Package seg7_pkg SHALL hold the 16-entry glyph constants, the FSM state encoding, and the blank-segment constant.
REQ-030 Combinational sub-module deco_hex_7seg (4-bit in, 7-bit out, active-high glyphs) SHALL be instantiated once on the muxed nibble; polarity inversion is done in the top.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2)
REQ-031 Reset, load i_Value=16'h1234 -> after first wrap, slots show digit0=7'h66, digit1=7'h4F, digit2=7'h5B, digit3=7'h06, one-hot o_Digito 0001..1000; o_Frame every 24 clocks.
REQ-032 Sweep nibble 0..F on digit 0 -> glyph table of REQ-014 matches exactly for all 16 codes.
REQ-033 Load 16'hAAAA mid-frame then 16'h5555 same frame -> current frame unchanged, next frame shows 5555 only; load on wrap clock -> appears one frame later.
REQ-034 i_DpMask=4'b0100, COMMON_ANODE=1 -> o_Dp low only during digit2 SHOW; all outputs high during BLANK and reset.
REQ-035 With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0007 -> digits 3..1 segments 0, digit0 7'h07; 16'h0000 -> digit0 7'h3F only; without macro digits 3..1 show 7'h3F.
REQ-036 Assert i_Rst_n low during SHOW of digit2 -> outputs inactive same cycle; after release first lit slot is digit 0 after 2 clocks, registers cleared.
